// File: rtl/resta_bcd_display.sv
// Converts an unsigned N-bit subtractor result to ND packed BCD digits (double-dabble) and 7-segment codes.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits on seg; bcd is unaffected.
module resta_bcd_display #(
    parameter int N  = 6,
    parameter int ND = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [N-1:0]      y,
    output logic              ready_out,
    output logic [4*ND-1:0]   bcd,
    output logic [7*ND-1:0]   seg,
    output logic              done
);

    function automatic longint pow10(input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    if (N < 2 || N > 16 || pow10(ND) <= (longint'(1) << N) - 1) begin : g_bad_params
        $error("resta_bcd_display: N must be 2..16 and 10**ND must exceed 2**N-1");
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
    localparam int CW = $clog2(N + 1);

    state_t            state, next_state;
    logic [N-1:0]      shifter;
    logic [4*ND-1:0]   scratch, adjusted;
    logic [CW-1:0]     count;
    logic [7*ND-1:0]   seg_next;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (valid_in) next_state = CONVERT;
            CONVERT: if (count == CW'(1)) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state == IDLE);
    end

    always_comb begin
        adjusted = scratch;
        for (int k = 0; k < ND; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) adjusted[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
    end

    // Each CONVERT cycle corrects digits, then shifts one result bit into the BCD scratch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shifter <= '0;
            scratch <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    shifter <= y;
                    scratch <= '0;
                    count   <= CW'(N);
                end
                CONVERT: begin
                    {scratch, shifter} <= {adjusted[4*ND-2:0], shifter, 1'b0};
                    count              <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        seg_next = '1;
        for (int k = 0; k < ND; k++) seg_next[7*k +: 7] = seg7(scratch[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic leading;
            leading = 1'b1;
            for (int k = ND - 1; k >= 1; k--) begin
                if (leading && scratch[4*k +: 4] == 4'd0) seg_next[7*k +: 7] = 7'h7F;
                else                                      leading = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd  <= '0;
            seg  <= '1;
            done <= 1'b0;
        end else begin
            done <= (state == UPDATE);
            if (state == UPDATE) begin
                bcd <= scratch;
                seg <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_resta_bcd_display.sv
// Randomized self-checking bench for resta_bcd_display against a cycle-count behavioural model.
module tb_resta_bcd_display;

    localparam int N  = 6;
    localparam int ND = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in;
    logic [N-1:0]      y;
    logic              ready_out, done;
    logic [4*ND-1:0]   bcd;
    logic [7*ND-1:0]   seg;

    logic              valid4, ready4, done4;
    logic [3:0]        y4;
    logic [7:0]        bcd4;
    logic [13:0]       seg4;
    logic              valid2, ready2, done2;
    logic [1:0]        y2;
    logic [3:0]        bcd2;
    logic [6:0]        seg2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    resta_bcd_display #(.N(N), .ND(ND)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .y(y),
        .ready_out(ready_out), .bcd(bcd), .seg(seg), .done(done));

    resta_bcd_display #(.N(4), .ND(2)) dut4 (
        .clk(clk), .reset(reset), .valid_in(valid4), .y(y4),
        .ready_out(ready4), .bcd(bcd4), .seg(seg4), .done(done4));

    resta_bcd_display #(.N(2), .ND(1)) dut2 (
        .clk(clk), .reset(reset), .valid_in(valid2), .y(y2),
        .ready_out(ready2), .bcd(bcd2), .seg(seg2), .done(done2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        r = '0;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
        return r;
    endfunction

    function automatic logic [7*ND-1:0] to_seg(input int v);
        logic [7*ND-1:0] r;
        int d;
        r = '1;
        for (int k = 0; k < ND; k++) begin
            d = (v / (10 ** k)) % 10;
            r[7*k +: 7] = SEG_TAB[d];
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && v < 10 ** k) r[7*k +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    // Model: an accepted value appears on bcd/seg with done exactly N+1 edges later; busy blocks input.
    int                busy;
    int                pend;
    logic [4*ND-1:0]   m_bcd;
    logic [7*ND-1:0]   m_seg;
    logic              m_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 0;
            pend   <= 0;
            m_bcd  <= '0;
            m_seg  <= '1;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (busy > 0) begin
                busy <= busy - 1;
                if (busy == 1) begin
                    m_bcd  <= to_bcd(pend);
                    m_seg  <= to_seg(pend);
                    m_done <= 1'b1;
                end
            end else if (valid_in) begin
                pend <= int'(y);
                busy <= N + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("ready", 32'(ready_out), 32'(busy == 0));
        check("done",  32'(done),      32'(m_done));
        check("bcd",   32'(bcd),       32'(m_bcd));
        check("seg",   32'(seg),       32'(m_seg));
    end

    task automatic send(input logic [N-1:0] v);
        valid_in = 1'b1;
        y        = v;
        @(negedge clk);
        valid_in = 1'b0;
        y        = N'($urandom);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, low, c4, c2, r;
        reset = 1'b1; valid_in = 1'b0; y = '0;
        valid4 = 1'b0; y4 = '0; valid2 = 1'b0; y2 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_bcd",   32'(bcd),       32'h0);
        check("rst_seg",   32'(seg),       32'h3FFF);
        check("rst_done",  32'(done),      32'd0);

        // Release reset and present the first value in the same cycle.
        reset = 1'b0;
        send(6'd62);
        wait_done(cyc);
        check("lat_62", 32'(cyc), 32'd7);
        check("bcd_62", 32'(bcd), 32'h62);
        check("seg_62", 32'(seg), 32'({7'h02, 7'h24}));

        send(6'd21);
        wait_done(cyc);
        check("bcd_21", 32'(bcd), 32'h21);
        check("seg_21", 32'(seg), 32'({7'h24, 7'h79}));
        send(6'd63);
        wait_done(cyc);
        check("lat_63", 32'(cyc), 32'd7);
        check("bcd_63", 32'(bcd), 32'h63);

        send(6'd5);
        wait_done(cyc);
        check("bcd_5", 32'(bcd), 32'h05);
`ifdef LEADING_ZERO_BLANK_EN
        check("seg_5", 32'(seg), 32'({7'h7F, 7'h12}));
`else
        check("seg_5", 32'(seg), 32'({7'h40, 7'h12}));
`endif

        // Inputs wiggle throughout the conversion and must be ignored.
        valid_in = 1'b1;
        y        = 6'd40;
        @(negedge clk);
        low = 0;
        for (int k = 0; k < 7; k++) begin
            if (!ready_out) low++;
            valid_in = 1'($urandom);
            y        = N'($urandom);
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("busy_cycles_40", 32'(low), 32'd7);
        check("done_40",        32'(done), 32'd1);
        check("bcd_40",         32'(bcd),  32'h40);
        repeat (3) @(negedge clk);

        send(6'd50);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_bcd",   32'(bcd),       32'h0);
        check("abort_seg",   32'(seg),       32'h3FFF);
        check("abort_ready", 32'(ready_out), 32'd1);
        check("abort_done",  32'(done),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        send(6'd9);
        wait_done(cyc);
        check("bcd_9", 32'(bcd), 32'h09);

        for (int i = 0; i < 1500; i++) begin
            valid_in = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            y = (r == 0) ? '0 : (r == 1) ? '1 : N'($urandom);
            @(negedge clk);
        end
        valid_in = 1'b0;
        repeat (10) @(negedge clk);

        // Narrow builds: N=4 ND=2 and N=2 ND=1.
        valid4 = 1'b1; y4 = 4'd14;
        valid2 = 1'b1; y2 = 2'd3;
        @(negedge clk);
        valid4 = 1'b0; valid2 = 1'b0;
        c4 = 0; c2 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done4) begin
                c4 = k;
                check("bcd4_14", 32'(bcd4), 32'h14);
                check("seg4_14", 32'(seg4), 32'({7'h79, 7'h19}));
            end
            if (done2) begin
                c2 = k;
                check("bcd2_3", 32'(bcd2), 32'h3);
                check("seg2_3", 32'(seg2), 32'h30);
            end
        end
        check("lat4", 32'(c4), 32'd5);
        check("lat2", 32'(c2), 32'd3);
        check("ready4", 32'(ready4), 32'd1);
        check("ready2", 32'(ready2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/resta_bcd_display.md
RESTA_BCD_DISPLAY -- requirements
Module: resta_bcd_display

Interface
REQ-001 SHALL have parameter N: default 6; width of the unsigned subtractor result, legal range 2..16.
REQ-002 SHALL have parameter ND: default 2; number of decimal digits; 10^ND SHALL exceed 2^N-1, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port valid_in, input, 1 bit: y holds a new result to convert.
REQ-006 SHALL have port y, input, N bits: registered difference from the upstream subtractor, treated as unsigned modulo 2^N.
REQ-007 SHALL have port ready_out, output, 1 bit: block idle and accepting.
REQ-008 SHALL have port bcd, output, 4*ND bits: packed BCD result; digit k is at bcd[4k+3:4k], with digit 0 least significant.
REQ-009 SHALL have port seg, output, 7*ND bits: active-low segments; digit k is at seg[7k+6:7k], bit order {g,f,e,d,c,b,a}.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when bcd/seg update.

Function
REQ-011 SHALL implement FSM states IDLE, CONVERT, UPDATE.
REQ-012 SHALL drive ready_out high exactly when state is IDLE, decoded combinationally from the state register.
REQ-013 In IDLE, when valid_in=1, SHALL capture y into an N-bit shift register, clear the scratch BCD register, load bit counter with N, and go to CONVERT.
REQ-014 In CONVERT, each cycle SHALL first add 3 to every scratch BCD digit >=5, then shift {scratch, shifter} left by one and decrement the counter.
REQ-015 SHALL leave CONVERT after exactly N cycles and enter UPDATE.
REQ-016 In UPDATE, SHALL register the scratch value onto bcd, register the decoded seg, pulse done=1 for that cycle, and return to IDLE.
REQ-017 Latency SHALL be N+1 cycles: done is high on the (N+1)th rising edge after the edge that accepted valid_in.
REQ-018 SHALL ignore valid_in in CONVERT and UPDATE, with no queuing; y changes during conversion SHALL not affect the result.
REQ-019 SHALL allow back-to-back operation: valid_in high in the cycle after UPDATE is accepted.
REQ-020 SHALL hold bcd and seg stable between done pulses.
REQ-021 Segment codes (hex, active-low) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; any non-BCD digit SHALL encode as 7F (blank).
REQ-022 SHALL convert y=2^N-1, the upstream wrap of 0-1, as a plain unsigned value with no sign handling.

Reset
REQ-023 Asserting reset SHALL immediately force state=IDLE, bcd=0, seg all ones (blank), done=0, and clear the shifter, scratch register and counter.
REQ-024 Reset mid-CONVERT or mid-UPDATE SHALL abort the conversion with no done pulse; after release, ready_out=1.
REQ-025 The first valid_in SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL blank (7F) every zero digit more significant than the most significant nonzero digit; digit 0 SHALL always be displayed.
REQ-027 Without LEADING_ZERO_BLANK_EN, SHALL display all ND digits, including leading zeros; bcd SHALL be identical in both builds.

Verification
REQ-028 N=6, ND=2, y=62 (63-1) with valid_in one cycle -> done 7 cycles later; bcd=0x62; seg[13:7]=02, seg[6:0]=24.
REQ-029 N=6, y=21 (42-21) -> bcd=0x21, seg=24/79; then y=63 (0-1 wrap) back-to-back -> bcd=0x63.
REQ-030 N=6, y=5: with LEADING_ZERO_BLANK_EN -> seg[13:7]=7F, seg[6:0]=12; without it -> seg[13:7]=40, seg[6:0]=12; bcd=0x05 in both builds.
REQ-031 N=6, accept y=40, change y and toggle valid_in during CONVERT -> single done, bcd=0x40, ready_out low for 7 cycles.
REQ-032 N=6, assert reset 3 cycles into conversion -> no done pulse, bcd=0, seg all ones, ready_out=1; the next conversion with y=9 yields bcd=0x09.
REQ-033 N=4, ND=2, y=14 (15-1) -> done after 5 cycles, bcd=0x14; N=2, ND=1, y=3 (0-1 wrap) -> bcd=0x3, seg=30.
